// File: rtl/ecc_enc_dec_core_if.sv
// Register-side bundle between the APB register selector (master) and the SECDED engine (slave).
// dbg_state mirrors the engine FSM encoding for observation only.
interface ecc_enc_dec_core_if #(
  parameter int AMBA_WORD = 32
);
  logic                 start;
  logic [AMBA_WORD-1:0] ctrl;
  logic [AMBA_WORD-1:0] data_in;
  logic [AMBA_WORD-1:0] codeword_width;
  logic [AMBA_WORD-1:0] noise;
  logic [AMBA_WORD-1:0] data_out;
  logic [1:0]           num_of_errors;
  logic                 operation_done;
  logic                 busy;
  logic [2:0]           dbg_state;

  // start is a single-cycle request with no ready: it is taken only while busy is low
  // and ctrl[1:0] is legal; operation_done is a single-cycle response that marks the
  // cycle in which data_out/num_of_errors hold the new result.
  modport master (
    output start, ctrl, data_in, codeword_width, noise,
    input  data_out, num_of_errors, operation_done, busy, dbg_state
  );

  modport slave (
    input  start, ctrl, data_in, codeword_width, noise,
    output data_out, num_of_errors, operation_done, busy, dbg_state
  );
endinterface

// File: rtl/ecc_enc_dec_core.sv
// Extended-Hamming (SECDED) encode / decode / full-channel engine for 8-, 16- and 32-bit codewords.
// Bit 0 is overall parity; parity bits sit at power-of-two positions; data fills the rest ascending.
module ecc_enc_dec_core #(
  parameter int AMBA_WORD = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  ecc_enc_dec_core_if.slave        bus
);

  typedef enum logic [2:0] {IDLE, ENC, CHAN, DEC, DONE} state_t;

  localparam logic [1:0] MODE_ENC     = 2'b00;
  localparam logic [1:0] MODE_DEC     = 2'b01;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  function automatic int width_n(input logic [1:0] w);
    case (w)
      2'b00:   width_n = 8;
      2'b01:   width_n = 16;
      default: width_n = 32;
    endcase
  endfunction

  function automatic logic [31:0] mask_cw(input logic [31:0] x, input logic [1:0] w);
    case (w)
      2'b00:   mask_cw = {24'b0, x[7:0]};
      2'b01:   mask_cw = {16'b0, x[15:0]};
      default: mask_cw = x;
    endcase
  endfunction

  function automatic logic [31:0] hamming_encode(input logic [31:0] d, input logic [1:0] w);
    logic [31:0] cw;
    logic [4:0]  k;
    logic        p;
    int          n;
    int          pos;
    n  = width_n(w);
    cw = '0;
    k  = '0;
    for (int i = 1; i < 32; i++) begin
      if (i < n && (i & (i - 1)) != 0) begin
        cw[i[4:0]] = d[k];
        k = k + 5'd1;
      end
    end
    // Parity slots are still zero here, so they do not disturb each other's sums.
    for (int j = 0; j < 5; j++) begin
      p = 1'b0;
      for (int i = 1; i < 32; i++) begin
        if (i < n && ((i >> j) & 1) != 0) p = p ^ cw[i[4:0]];
      end
      pos = 1 << j;
      if (pos < n) cw[pos[4:0]] = p;
    end
    cw[0] = ^cw[31:1];
    hamming_encode = cw;
  endfunction

  function automatic logic [4:0] syndrome(input logic [31:0] cw);
    logic [4:0] s;
    s = '0;
    for (int i = 1; i < 32; i++) begin
      if (cw[i[4:0]]) s = s ^ i[4:0];
    end
    syndrome = s;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] cw, input logic [1:0] w);
    logic [31:0] d;
    logic [4:0]  k;
    int          n;
    n = width_n(w);
    d = '0;
    k = '0;
    for (int i = 1; i < 32; i++) begin
      if (i < n && (i & (i - 1)) != 0) begin
        d[k] = cw[i[4:0]];
        k = k + 5'd1;
      end
    end
    extract = d;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            width_q, width_d;
  logic [AMBA_WORD-1:0]  data_q, data_d;
  logic [AMBA_WORD-1:0]  noise_q, noise_d;
  logic [31:0]           cw_q, cw_d;
  logic [4:0]            syn_q, syn_d;
  logic                  par_q, par_d;
  logic [AMBA_WORD-1:0]  data_out_q, data_out_d;
  logic [1:0]            err_q, err_d;
  logic                  done_q, done_d;
  logic [31:0]           fixed_cw;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    width_d    = width_q;
    data_d     = data_q;
    noise_d    = noise_q;
    cw_d       = cw_q;
    syn_d      = syn_q;
    par_d      = par_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    done_d     = 1'b0;
    fixed_cw   = cw_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.ctrl[1:0] != MODE_ILLEGAL) begin
          mode_d  = bus.ctrl[1:0];
          width_d = bus.codeword_width[1:0];
          data_d  = bus.data_in;
          noise_d = bus.noise;
          // A plain decode gets its syndrome precomputed here so DEC only corrects.
          cw_d    = mask_cw(bus.data_in, bus.codeword_width[1:0]);
          syn_d   = syndrome(cw_d);
          par_d   = ^cw_d;
          state_d = (bus.ctrl[1:0] == MODE_DEC) ? DEC : ENC;
        end
      end
      ENC: begin
        cw_d = hamming_encode(data_q, width_q);
        if (mode_q == MODE_ENC) begin
          data_out_d = cw_d;
          err_d      = 2'b00;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = CHAN;
        end
      end
      CHAN: begin
        cw_d    = cw_q ^ mask_cw(noise_q, width_q);
        syn_d   = syndrome(cw_d);
        par_d   = ^cw_d;
        state_d = DEC;
      end
      DEC: begin
        // Odd overall parity means one flipped bit; syndrome 0 points at the parity bit itself.
        if (par_q) fixed_cw[syn_q] = ~fixed_cw[syn_q];
        data_out_d = extract(fixed_cw, width_q);
        err_d      = par_q ? 2'b01 : ((syn_q != 5'd0) ? 2'b10 : 2'b00);
        done_d     = 1'b1;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      width_q    <= '0;
      data_q     <= '0;
      noise_q    <= '0;
      cw_q       <= '0;
      syn_q      <= '0;
      par_q      <= 1'b0;
      data_out_q <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      width_q    <= width_d;
      data_q     <= data_d;
      noise_q    <= noise_d;
      cw_q       <= cw_d;
      syn_q      <= syn_d;
      par_q      <= par_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.num_of_errors  = err_q;
  assign bus.operation_done = done_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.dbg_state      = state_q;

  logic unused_reg_bits;
  assign unused_reg_bits = ^{bus.ctrl[AMBA_WORD-1:2], bus.codeword_width[AMBA_WORD-1:2]};

endmodule
